router_data_register: RTL and testbench

Datapath register stage of the 1x3 router, placed between the packet input port and the three output FIFOs and sequenced by the router FSM controller's state strobes (`detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`). It latches the header byte and drives it first. It then forwards payload bytes to the FIFO write bus, holding one byte across a FIFO-full stall. It accumulates byte-wise XOR parity, compares it against the trailing parity byte, and returns `parity_done` and `low_pkt_valid` to the controller.

---
 rtl/router_data_register_if.sv | 31 +++
 rtl/router_data_register.sv | 118 +++++++++++
 tb/tb_router_data_register.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/router_data_register_if.sv
// Signal bundle between the router controller/input port and the data register stage.
// The master drives packet bytes and state strobes; the slave returns the FIFO byte and status.
interface router_data_register_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic [DATA_WIDTH-1:0] dout;
    logic                  parity_done;
    logic                  low_pkt_valid;
    logic                  err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_data_register.sv
// Router datapath register: latches the header, forwards payload to the FIFO bus with a
// one-byte stall buffer, and checks running XOR parity against the trailing parity byte.
module router_data_register #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    router_data_register_if.slave bus
);
    logic [DATA_WIDTH-1:0] header_byte_q, header_byte_d;
    logic [DATA_WIDTH-1:0] hold_byte_q, hold_byte_d;
    logic                  hold_is_payload_q, hold_is_payload_d;
    logic [DATA_WIDTH-1:0] internal_parity_q, internal_parity_d;
    logic [DATA_WIDTH-1:0] packet_parity_q, packet_parity_d;
    logic                  check_pending_q, check_pending_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;
    logic                  err_q, err_d;

    always_comb begin
        header_byte_d     = header_byte_q;
        hold_byte_d       = hold_byte_q;
        hold_is_payload_d = hold_is_payload_q;
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        check_pending_d   = check_pending_q;
        dout_d            = dout_q;
        parity_done_d     = parity_done_q;
        low_pkt_valid_d   = low_pkt_valid_q;
        err_d             = err_q;

        // Compare runs the cycle after the parity byte lands; a new header overrides it below.
        if (check_pending_q) begin
            err_d           = (internal_parity_q != packet_parity_q);
            check_pending_d = 1'b0;
        end

        unique case (1'b1)
            bus.detect_add: begin
                if (bus.pkt_valid && (bus.data_in[1:0] != 2'b11)) begin
                    header_byte_d = bus.data_in;
                end
                internal_parity_d = '0;
                packet_parity_d   = '0;
                parity_done_d     = 1'b0;
                err_d             = 1'b0;
                check_pending_d   = 1'b0;
            end
            bus.lfd_state: begin
                dout_d            = header_byte_q;
                internal_parity_d = header_byte_q;
            end
            bus.ld_state: begin
                if (!bus.fifo_full) begin
                    dout_d = bus.data_in;
                    if (bus.pkt_valid) begin
                        internal_parity_d = internal_parity_q ^ bus.data_in;
                    end else begin
                        packet_parity_d = bus.data_in;
                        parity_done_d   = 1'b1;
                        check_pending_d = 1'b1;
                    end
                end else begin
                    hold_byte_d       = bus.data_in;
                    hold_is_payload_d = bus.pkt_valid;
                end
                if (!bus.pkt_valid) begin
                    low_pkt_valid_d = 1'b1;
                end
            end
            bus.laf_state: begin
                dout_d = hold_byte_q;
                if (hold_is_payload_q) begin
                    internal_parity_d = internal_parity_q ^ hold_byte_q;
                end else begin
                    packet_parity_d = hold_byte_q;
                    parity_done_d   = 1'b1;
                    check_pending_d = 1'b1;
                end
            end
            bus.full_state: ;
            bus.rst_int_reg: low_pkt_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            header_byte_q     <= '0;
            hold_byte_q       <= '0;
            hold_is_payload_q <= 1'b0;
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            check_pending_q   <= 1'b0;
            dout_q            <= '0;
            parity_done_q     <= 1'b0;
            low_pkt_valid_q   <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            header_byte_q     <= header_byte_d;
            hold_byte_q       <= hold_byte_d;
            hold_is_payload_q <= hold_is_payload_d;
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            check_pending_q   <= check_pending_d;
            dout_q            <= dout_d;
            parity_done_q     <= parity_done_d;
            low_pkt_valid_q   <= low_pkt_valid_d;
            err_q             <= err_d;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_router_data_register.sv
// Cycle-by-cycle bench for router_data_register: each vector drives one cycle of strobes and
// data, queues the outputs expected after that edge, and compares them once the edge has passed.
module tb_router_data_register;
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FULL = 6'b000010;
    localparam logic [5:0] S_RI   = 6'b000001;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [7:0] din;
        logic       ff;
        logic [5:0] st;
        logic [7:0] e_dout;
        logic       e_pd;
        logic       e_lpv;
        logic       e_err;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       pd;
        logic       lpv;
        logic       err;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    vec_t tbl[$];
    exp_t sb[$];

    router_data_register_if #(.DATA_WIDTH(8)) bus ();

    router_data_register #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic rst, input logic pv, input logic [7:0] din,
                               input logic ff, input logic [5:0] st, input logic [7:0] e_dout,
                               input logic e_pd, input logic e_lpv, input logic e_err,
                               input string name);
        vec_t r;
        r.rst = rst; r.pv = pv; r.din = din; r.ff = ff; r.st = st;
        r.e_dout = e_dout; r.e_pd = e_pd; r.e_lpv = e_lpv; r.e_err = e_err; r.name = name;
        return r;
    endfunction

    task automatic check(input string name, input string field, input logic [7:0] act,
                         input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    task automatic step(input vec_t t);
        exp_t e;
        @(negedge clk);
        reset         = t.rst;
        bus.pkt_valid = t.pv;
        bus.data_in   = t.din;
        bus.fifo_full = t.ff;
        {bus.detect_add, bus.lfd_state, bus.ld_state,
         bus.laf_state, bus.full_state, bus.rst_int_reg} = t.st;
        e.dout = t.e_dout; e.pd = t.e_pd; e.lpv = t.e_lpv; e.err = t.e_err; e.name = t.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", t.name);
        end else begin
            e = sb.pop_front();
            check(e.name, "dout", bus.dout, e.dout);
            check(e.name, "parity_done", {7'd0, bus.parity_done}, {7'd0, e.pd});
            check(e.name, "low_pkt_valid", {7'd0, bus.low_pkt_valid}, {7'd0, e.lpv});
            check(e.name, "err", {7'd0, bus.err}, {7'd0, e.err});
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        bus.fifo_full = 1'b0;
        {bus.detect_add, bus.lfd_state, bus.ld_state,
         bus.laf_state, bus.full_state, bus.rst_int_reg} = S_NONE;

        // Good packet, then the same packet with a bad parity byte.
        //          rst  pv   din    ff   st      dout   pd   lpv  err
        tbl.push_back(v(1, 0, 8'h00, 0, S_NONE, 8'h00, 0, 0, 0, "reset"));
        tbl.push_back(v(0, 1, 8'h0D, 0, S_DA,   8'h00, 0, 0, 0, "good_da"));
        tbl.push_back(v(0, 1, 8'h11, 0, S_LFD,  8'h0D, 0, 0, 0, "good_lfd"));
        tbl.push_back(v(0, 1, 8'h11, 0, S_LD,   8'h11, 0, 0, 0, "good_p0"));
        tbl.push_back(v(0, 1, 8'h22, 0, S_LD,   8'h22, 0, 0, 0, "good_p1"));
        tbl.push_back(v(0, 1, 8'h33, 0, S_LD,   8'h33, 0, 0, 0, "good_p2"));
        tbl.push_back(v(0, 0, 8'h0D, 0, S_LD,   8'h0D, 1, 1, 0, "good_par"));
        tbl.push_back(v(0, 0, 8'h00, 0, S_NONE, 8'h0D, 1, 1, 0, "good_err"));
        tbl.push_back(v(0, 0, 8'h00, 0, S_RI,   8'h0D, 1, 0, 0, "good_rst_int"));
        tbl.push_back(v(0, 1, 8'h0D, 0, S_DA,   8'h0D, 0, 0, 0, "bad_da"));
        tbl.push_back(v(0, 1, 8'h11, 0, S_LFD,  8'h0D, 0, 0, 0, "bad_lfd"));
        tbl.push_back(v(0, 1, 8'h11, 0, S_LD,   8'h11, 0, 0, 0, "bad_p0"));
        tbl.push_back(v(0, 1, 8'h22, 0, S_LD,   8'h22, 0, 0, 0, "bad_p1"));
        tbl.push_back(v(0, 1, 8'h33, 0, S_LD,   8'h33, 0, 0, 0, "bad_p2"));
        tbl.push_back(v(0, 0, 8'h00, 0, S_LD,   8'h00, 1, 1, 0, "bad_par"));
        tbl.push_back(v(0, 0, 8'h00, 0, S_NONE, 8'h00, 1, 1, 1, "bad_err"));
        tbl.push_back(v(0, 0, 8'h00, 0, S_NONE, 8'h00, 1, 1, 1, "bad_err_hold"));
        tbl.push_back(v(0, 0, 8'h00, 0, S_RI,   8'h00, 1, 0, 1, "bad_rst_int"));
        tbl.push_back(v(0, 1, 8'h0D, 0, S_DA,   8'h00, 0, 0, 0, "bad_err_clear"));
        foreach (tbl[i]) step(tbl[i]);

        // FIFO-full stall on a payload byte (header 0D already latched).
        step(v(0, 1, 8'h11, 0, S_LFD,  8'h0D, 0, 0, 0, "stall_lfd"));
        step(v(0, 1, 8'h11, 0, S_LD,   8'h11, 0, 0, 0, "stall_p0"));
        step(v(0, 1, 8'h22, 1, S_LD,   8'h11, 0, 0, 0, "stall_hold"));
        for (int i = 0; i < 3; i++) begin
            step(v(0, 1, 8'h33, 1, S_FULL, 8'h11, 0, 0, 0, "stall_full"));
        end
        step(v(0, 1, 8'h33, 0, S_LAF,  8'h22, 0, 0, 0, "stall_laf"));
        step(v(0, 1, 8'h33, 0, S_LD,   8'h33, 0, 0, 0, "stall_p2"));
        step(v(0, 0, 8'h0D, 0, S_LD,   8'h0D, 1, 1, 0, "stall_par"));
        step(v(0, 0, 8'h00, 0, S_NONE, 8'h0D, 1, 1, 0, "stall_err"));
        step(v(0, 0, 8'h00, 0, S_RI,   8'h0D, 1, 0, 0, "stall_rst_int"));

        // Parity byte arrives while the FIFO is full; absorbed on the laf cycle.
        step(v(0, 1, 8'h0D, 0, S_DA,   8'h0D, 0, 0, 0, "pfull_da"));
        step(v(0, 1, 8'h11, 0, S_LFD,  8'h0D, 0, 0, 0, "pfull_lfd"));
        step(v(0, 1, 8'h11, 0, S_LD,   8'h11, 0, 0, 0, "pfull_p0"));
        step(v(0, 1, 8'h22, 0, S_LD,   8'h22, 0, 0, 0, "pfull_p1"));
        step(v(0, 1, 8'h33, 0, S_LD,   8'h33, 0, 0, 0, "pfull_p2"));
        step(v(0, 0, 8'h0E, 1, S_LD,   8'h33, 0, 1, 0, "pfull_hold"));
        step(v(0, 0, 8'h00, 1, S_FULL, 8'h33, 0, 1, 0, "pfull_full"));
        step(v(0, 0, 8'h00, 0, S_LAF,  8'h0E, 1, 1, 0, "pfull_laf"));
        step(v(0, 0, 8'h00, 0, S_NONE, 8'h0E, 1, 1, 1, "pfull_err"));

        // Reset mid-packet, then address-3 headers must not replace the latched header.
        step(v(0, 1, 8'h05, 0, S_DA,   8'h0E, 0, 1, 0, "rst_da"));
        step(v(0, 1, 8'hAA, 0, S_LFD,  8'h05, 0, 1, 0, "rst_lfd"));
        step(v(0, 1, 8'hAA, 0, S_LD,   8'hAA, 0, 1, 0, "rst_p0"));
        step(v(1, 1, 8'hBB, 0, S_LD,   8'h00, 0, 0, 0, "rst_mid"));
        step(v(0, 1, 8'h0F, 0, S_DA,   8'h00, 0, 0, 0, "addr3_da"));
        step(v(0, 1, 8'h00, 0, S_LFD,  8'h00, 0, 0, 0, "addr3_lfd"));
        step(v(0, 1, 8'h16, 0, S_DA,   8'h00, 0, 0, 0, "addr2_da"));
        step(v(0, 1, 8'h1F, 0, S_DA,   8'h00, 0, 0, 0, "addr3_da2"));
        step(v(0, 1, 8'h00, 0, S_LFD,  8'h16, 0, 0, 0, "addr3_keep"));

        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
